glb_port_arbiter: RTL and testbench



---
 rtl/glb_port_arbiter.sv | 129 ++++++++++++
 tb/tb_glb_port_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/glb_port_arbiter.sv
// glb_port_arbiter: round-robin sharing of the GLB read/write ports among NUM_REQ requesters; define GLB_RAW_STALL_EN to hold back reads overlapping a same-cycle write
module glb_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0]                req_wr,
  input  logic [2*NUM_REQ-1:0]              req_size,
  input  logic [ADDR_WIDTH*NUM_REQ-1:0]     req_addr,
  input  logic [DATA_WIDTH*4*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [DATA_WIDTH*4-1:0]           rsp_rdata,
  output logic [3:0]                        glb_re,
  output logic [ADDR_WIDTH-1:0]             glb_r_addr,
  input  logic [DATA_WIDTH*4-1:0]           glb_dout,
  output logic [3:0]                        glb_we,
  output logic [ADDR_WIDTH-1:0]             glb_w_addr,
  output logic [DATA_WIDTH*4-1:0]           glb_din,
  output logic                              busy
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int BW = DATA_WIDTH * 4;

  logic [ADDR_WIDTH-1:0] w_addr  [NUM_REQ];
  logic [1:0]            w_size  [NUM_REQ];
  logic [BW-1:0]         w_wdata [NUM_REQ];
  logic [NUM_REQ-1:0]    w_rd_cand;
  logic [PW:0]           w_wr_pick, w_rd_pick;
  logic                  w_wr_gnt, w_rd_gnt;
  logic [PW-1:0]         w_wr_idx, w_rd_idx;
  logic [PW-1:0]         r_rd_ptr, r_wr_ptr, r_rd_tag;
  logic [3:0]            r_re, r_we;
  logic [ADDR_WIDTH-1:0] r_r_addr, r_w_addr;
  logic [BW-1:0]         r_din;
  logic [NUM_REQ-1:0]    r_rsp_valid;

  function automatic logic [3:0] size_mask(input logic [1:0] s);
    return {s == 2'd3, s >= 2'd2, s != 2'd0, 1'b1};
  endfunction

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // Lowest set candidate at or after ptr (wrapping); returns {found, index}.
  function automatic logic [PW:0] rr_pick(input logic [NUM_REQ-1:0] cand, input logic [PW-1:0] ptr);
    logic [NUM_REQ-1:0] rot;
    logic [PW:0]        res, s;
    rot = NUM_REQ'({cand, cand} >> ptr);
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      s = {1'b0, ptr} + (PW+1)'(k);
      if (rot[k]) res = {1'b1, (s >= (PW+1)'(NUM_REQ)) ? PW'(s - (PW+1)'(NUM_REQ)) : s[PW-1:0]};
    end
    return res;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign w_addr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_size[g]  = req_size[2*g +: 2];
    assign w_wdata[g] = req_wdata[g*BW +: BW];
  end

  assign w_wr_pick = rr_pick(req_valid & req_wr, r_wr_ptr);
  assign w_wr_gnt  = w_wr_pick[PW];
  assign w_wr_idx  = w_wr_pick[PW-1:0];

`ifdef GLB_RAW_STALL_EN
  logic [ADDR_WIDTH:0] w_end [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_end
    assign w_end[g] = {1'b0, w_addr[g]} + (ADDR_WIDTH+1)'(w_size[g]);
  end
  // Reads whose byte range meets the granted write's range wait for a later cycle
  always_comb begin
    w_rd_cand = '0;
    for (int i = 0; i < NUM_REQ; i++)
      w_rd_cand[i] = req_valid[i] & ~req_wr[i] & ~(w_wr_gnt & ({1'b0, w_addr[i]} <= w_end[w_wr_idx]) & ({1'b0, w_addr[w_wr_idx]} <= w_end[i]));
  end
`else
  assign w_rd_cand = req_valid & ~req_wr;
`endif

  assign w_rd_pick = rr_pick(w_rd_cand, r_rd_ptr);
  assign w_rd_gnt  = w_rd_pick[PW];
  assign w_rd_idx  = w_rd_pick[PW-1:0];

  // One-hot acceptance of this cycle's read and write grantees
  always_comb begin
    req_ready = rst ? '0 : ((w_wr_gnt ? NUM_REQ'(1) << w_wr_idx : '0) | (w_rd_gnt ? NUM_REQ'(1) << w_rd_idx : '0));
  end

  // Issue stage, read tag/response stage and round-robin pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_re        <= '0;
      r_r_addr    <= '0;
      r_we        <= '0;
      r_w_addr    <= '0;
      r_din       <= '0;
      r_rd_tag    <= '0;
      r_rsp_valid <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
    end else begin
      r_re        <= w_rd_gnt ? size_mask(w_size[w_rd_idx]) : '0;
      r_r_addr    <= w_rd_gnt ? w_addr[w_rd_idx] : '0;
      r_rd_tag    <= w_rd_gnt ? w_rd_idx : '0;
      r_we        <= w_wr_gnt ? size_mask(w_size[w_wr_idx]) : '0;
      r_w_addr    <= w_wr_gnt ? w_addr[w_wr_idx] : '0;
      r_din       <= w_wr_gnt ? w_wdata[w_wr_idx] : '0;
      r_rsp_valid <= (|r_re) ? NUM_REQ'(1) << r_rd_tag : '0;
      r_rd_ptr    <= w_rd_gnt ? next_idx(w_rd_idx) : r_rd_ptr;
      r_wr_ptr    <= w_wr_gnt ? next_idx(w_wr_idx) : r_wr_ptr;
    end
  end

  assign glb_re     = r_re;
  assign glb_r_addr = r_r_addr;
  assign glb_we     = r_we;
  assign glb_w_addr = r_w_addr;
  assign glb_din    = r_din;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = glb_dout;
  assign busy       = |r_re | |r_we | |r_rsp_valid;
endmodule

// File: tb/tb_glb_port_arbiter.sv
// tb_glb_port_arbiter: scoreboard bench with a GLB memory model and a byte-level reference model
module tb_glb_port_arbiter;
  localparam int N = 4;
`ifdef GLB_RAW_STALL_EN
  localparam bit RAW = 1'b1;
`else
  localparam bit RAW = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready, req_wr = '0, rsp_valid;
  logic [2*N-1:0] req_size = '0;
  logic [32*N-1:0] req_addr = '0, req_wdata = '0;
  logic [31:0] rsp_rdata, glb_dout = '0, glb_r_addr, glb_w_addr, glb_din;
  logic [3:0] glb_re, glb_we;
  logic busy;

  glb_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .glb_re(glb_re), .glb_r_addr(glb_r_addr), .glb_dout(glb_dout),
    .glb_we(glb_we), .glb_w_addr(glb_w_addr), .glb_din(glb_din), .busy(busy));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit [7:0] glb_mem [1024];
  bit [7:0] ref_mem [1024];

  // GLB macro model: registered read of the enabled bytes (zero-filled), read-before-write
  always @(posedge clk) begin
    logic [31:0] rd;
    rd = '0;
    for (int b = 0; b < 4; b++) if (glb_re[b]) rd[8*b +: 8] = glb_mem[(glb_r_addr + b) % 1024];
    if (glb_re != 0) glb_dout <= rd;
    for (int b = 0; b < 4; b++) if (glb_we[b]) glb_mem[(glb_w_addr + b) % 1024] = glb_din[8*b +: 8];
  end

  typedef struct {int due; logic [3:0] re; logic [31:0] ra; logic [3:0] we; logic [31:0] wa; logic [31:0] din;} iss_t;
  typedef struct {int due; int tag; logic [31:0] data;} rsp_t;
  iss_t iss_q[$];
  rsp_t rsp_q[$];

  int total = 0, bad = 0, rp = 0, wp = 0;
  logic [N-1:0] s_v, s_w;
  logic [1:0] s_s [N];
  logic [31:0] s_a [N], s_d [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] mask_of(input int s);
    return 4'((1 << (s + 1)) - 1);
  endfunction

  function automatic bit overlap(input int r, input int w);
    for (int i = 0; i <= int'(s_s[r]); i++)
      for (int j = 0; j <= int'(s_s[w]); j++)
        if (s_a[r] + i == s_a[w] + j) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    req_valid = s_v;
    req_wr = s_w;
    for (int i = 0; i < N; i++) begin
      req_size[2*i +: 2] = s_s[i];
      req_addr[32*i +: 32] = s_a[i];
      req_wdata[32*i +: 32] = s_d[i];
    end
  endtask

  // One cycle of stimulus; the reference model decides grants and predicts everything downstream
  task automatic step();
    int wg, rg, j;
    logic [N-1:0] rdy;
    logic [31:0] data;
    iss_t e;
    drive();
    wg = -1;
    rg = -1;
    for (int k = 0; k < N; k++) begin
      j = (wp + k) % N;
      if (wg < 0 && s_v[j] && s_w[j]) wg = j;
    end
    for (int k = 0; k < N; k++) begin
      j = (rp + k) % N;
      if (rg < 0 && s_v[j] && !s_w[j] && !(RAW && wg >= 0 && overlap(j, wg))) rg = j;
    end
    rdy = '0;
    if (wg >= 0) rdy[wg] = 1'b1;
    if (rg >= 0) rdy[rg] = 1'b1;
    #1 chk("req_ready", 32'(req_ready), 32'(rdy));
    e = '{cyc + 1, 4'h0, 32'h0, 4'h0, 32'h0, 32'h0};
    if (rg >= 0) begin
      data = '0;
      for (int b = 0; b <= int'(s_s[rg]); b++) data[8*b +: 8] = ref_mem[(s_a[rg] + b) % 1024];
      rsp_q.push_back('{cyc + 2, rg, data});
      e.re = mask_of(int'(s_s[rg]));
      e.ra = s_a[rg];
      rp = (rg + 1) % N;
    end
    if (wg >= 0) begin
      for (int b = 0; b <= int'(s_s[wg]); b++) ref_mem[(s_a[wg] + b) % 1024] = s_d[wg][8*b +: 8];
      e.we = mask_of(int'(s_s[wg]));
      e.wa = s_a[wg];
      e.din = s_d[wg];
      wp = (wg + 1) % N;
    end
    iss_q.push_back(e);
    @(posedge clk) #1;
  endtask

  task automatic idle(input int n);
    s_v = '0;
    repeat (n) step();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    s_v = '0;
    drive();
    while (rsp_q.size() != 0 && rsp_q[$].due > cyc) void'(rsp_q.pop_back());
    rp = 0;
    wp = 0;
    repeat (n) begin
      #1 chk("req_ready_in_reset", 32'(req_ready), 32'h0);
      iss_q.push_back('{cyc + 1, 4'h0, 32'h0, 4'h0, 32'h0, 32'h0});
      @(posedge clk) #1;
    end
    rst = 1'b0;
  endtask

  task automatic preload(input int a, input logic [31:0] d);
    for (int b = 0; b < 4; b++) begin
      glb_mem[a + b] = d[8*b +: 8];
      ref_mem[a + b] = d[8*b +: 8];
    end
  endtask

  // Monitor: compares issue-port state every cycle and pops read responses as the DUT presents them
  always @(negedge clk) begin
    iss_t e;
    rsp_t r;
    bit due_now;
    if (iss_q.size() != 0 && iss_q[0].due == cyc) begin
      e = iss_q.pop_front();
      due_now = rsp_q.size() != 0 && rsp_q[0].due == cyc;
      chk("glb_re", 32'(glb_re), 32'(e.re));
      chk("glb_r_addr", glb_r_addr, e.ra);
      chk("glb_we", 32'(glb_we), 32'(e.we));
      chk("glb_w_addr", glb_w_addr, e.wa);
      if (e.we != 0) chk("glb_din", glb_din, e.din);
      chk("busy", 32'(busy), 32'(e.re != 0 || e.we != 0 || due_now));
    end
    if (rsp_valid != 0) begin
      if (rsp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected at cycle %0d: got rsp_valid=%b, expected none", cyc, rsp_valid);
      end else begin
        r = rsp_q.pop_front();
        chk("rsp_cycle", 32'(cyc), 32'(r.due));
        chk("rsp_valid", 32'(rsp_valid), 32'(1) << r.tag);
        chk("rsp_rdata", rsp_rdata, r.data);
      end
    end else if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
      r = rsp_q.pop_front();
      total++;
      bad++;
      $display("FAIL rsp_missing at cycle %0d: got rsp_valid=0, expected tag %0d", cyc, r.tag);
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      s_s[i] = '0;
      s_a[i] = '0;
      s_d[i] = '0;
    end
    s_v = '0;
    s_w = '0;
    repeat (2) @(posedge clk);
    #1 do_reset(2);
    idle(1);
    preload(32'h10, 32'hDEADBEEF);
    s_v = 4'b0010; s_w = 4'b0000; s_s[1] = 2'd3; s_a[1] = 32'h10;
    step();
    idle(3);
    s_v = 4'b1111; s_w = 4'b0000;
    for (int i = 0; i < N; i++) begin s_s[i] = 2'd3; s_a[i] = 32'h10 + 4 * i; end
    repeat (8) step();
    idle(3);
    s_v = 4'b0101; s_w = 4'b0001;
    s_a[0] = 32'h100; s_s[0] = 2'd3; s_d[0] = 32'h11223344;
    s_a[2] = 32'h200; s_s[2] = 2'd1;
    step();
    idle(3);
    s_v = 4'b0011; s_w = 4'b0001;
    s_a[0] = 32'h40; s_s[0] = 2'd3; s_d[0] = 32'hAABBCCDD;
    s_a[1] = 32'h42; s_s[1] = 2'd0;
    step();
    s_v = 4'b0010;
    step();
    idle(3);
    s_v = 4'b0001; s_w = 4'b0001; s_a[0] = 32'h80; s_s[0] = 2'd1; s_d[0] = 32'h99887766;
    step();
    s_v = 4'b1000; s_w = 4'b0000; s_a[3] = 32'h80; s_s[3] = 2'd3;
    step();
    idle(3);
    s_v = 4'b0100; s_w = 4'b0000; s_a[2] = 32'h10; s_s[2] = 2'd3;
    step();
    do_reset(2);
    s_v = 4'b1111; s_w = 4'b0000;
    repeat (2) step();
    idle(3);
    repeat (600) begin
      s_v = 4'($urandom);
      s_w = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        s_s[i] = 2'($urandom);
        s_a[i] = 32'h300 + $urandom_range(0, 23);
        s_d[i] = $urandom;
      end
      step();
    end
    idle(4);
    chk("rsp_queue_drained", 32'(rsp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
